// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default frame shape and line levels.
// Used by the transmitter and intended for the matching receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } uart_state_e;

   localparam int unsigned DEFAULT_DATA_BITS = 8;
   localparam int unsigned DEFAULT_STOP_BITS = 1;

   localparam logic LINE_IDLE  = 1'b1;
   localparam logic LINE_START = 1'b0;
   localparam logic LINE_STOP  = 1'b1;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO for the UART transmitter; full/empty come from the occupancy count.
// Pushes while full and pops while empty are ignored.
module uart_tx_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wdata,
   input  logic                   pop,
   output logic [WIDTH-1:0]       rdata,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == CntW'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem_q[rd_ptr_q];
   assign count   = count_q;

   // Pointers are exactly log2(DEPTH) wide, so increments wrap modulo DEPTH.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// FIFO-buffered UART transmitter: one line bit per baud tick, LSB first, gap-free frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the payload and stop bits.
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS  = DEFAULT_DATA_BITS,
   parameter int unsigned STOP_BITS  = DEFAULT_STOP_BITS,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        tick,
   input  logic [DATA_BITS-1:0]        data_in,
   input  logic                        valid_in,
   output logic                        ready_out,
   output logic                        tx,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   localparam int unsigned IdxW = $clog2(DATA_BITS);

   uart_state_e          state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [IdxW-1:0]      idx_q, idx_d;
   logic                 stop_q, stop_d;
   logic                 tx_q, tx_d;
   logic                 load;

   logic                 fifo_pop;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [DATA_BITS-1:0] fifo_head;

`ifdef UART_TX_PARITY_EN
   logic                 parity_q, parity_d;
`endif

   uart_tx_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (valid_in && ready_out),
      .wdata (data_in),
      .pop   (fifo_pop),
      .rdata (fifo_head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign ready_out = !fifo_full;
   assign tx        = tx_q;
   assign busy      = (state_q != StIdle);

   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      idx_d    = idx_q;
      stop_d   = stop_q;
      tx_d     = tx_q;
      load     = 1'b0;
      fifo_pop = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d = parity_q;
`endif
      if (tick) begin
         case (state_q)
            StIdle: begin
               load = !fifo_empty;
            end
            StStart: begin
               tx_d    = shift_q[0];
               idx_d   = '0;
               state_d = StData;
            end
            StData: begin
               if (idx_q == IdxW'(DATA_BITS - 1)) begin
                  stop_d = 1'b0;
`ifdef UART_TX_PARITY_EN
                  tx_d    = parity_q;
                  state_d = StParity;
`else
                  tx_d    = LINE_STOP;
                  state_d = StStop;
`endif
               end else begin
                  shift_d = shift_q >> 1;
                  tx_d    = shift_d[0];
                  idx_d   = idx_q + IdxW'(1);
               end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
               tx_d    = LINE_STOP;
               state_d = StStop;
            end
`endif
            StStop: begin
               if (stop_q == 1'(STOP_BITS - 1)) begin
                  // Refill straight from the FIFO so consecutive frames have no idle gap.
                  load = !fifo_empty;
                  if (fifo_empty) begin
                     tx_d    = LINE_IDLE;
                     state_d = StIdle;
                  end
               end else begin
                  stop_d = 1'b1;
               end
            end
            default: begin
               tx_d    = LINE_IDLE;
               state_d = StIdle;
            end
         endcase
      end

      if (load) begin
         fifo_pop = 1'b1;
         shift_d  = fifo_head;
         tx_d     = LINE_START;
         state_d  = StStart;
`ifdef UART_TX_PARITY_EN
         parity_d = ^fifo_head;
`endif
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         shift_q <= '0;
         idx_q   <= '0;
         stop_q  <= 1'b0;
         tx_q    <= LINE_IDLE;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         stop_q  <= stop_d;
         tx_q    <= tx_d;
      end
   end

`ifdef UART_TX_PARITY_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= parity_d;
      end
   end
`endif

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a byte-queue / line-bit-queue model predicts tx, busy and
// fifo_count after every baud tick; a second instance covers two stop bits.
module tb_uart_tx;

   localparam int unsigned DB    = 8;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned STOPS = 1;
   localparam int unsigned CW    = $clog2(DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
   localparam int unsigned PAR = 1;
`else
   localparam int unsigned PAR = 0;
`endif

   logic          clk = 1'b0;
   logic          reset, tick, valid_in, valid2;
   logic [DB-1:0] data_in, data2;
   logic          ready_out, tx, busy, ready2, tx2, busy2;
   logic [CW-1:0] fifo_count, count2;

   int vectors = 0;
   int errors  = 0;

   byte unsigned mfifo[$];
   bit           mline[$];

   always #5 clk = ~clk;

   uart_tx #(.DATA_BITS(DB), .STOP_BITS(STOPS), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .tick(tick), .data_in(data_in), .valid_in(valid_in),
      .ready_out(ready_out), .tx(tx), .busy(busy), .fifo_count(fifo_count)
   );

   uart_tx #(.DATA_BITS(DB), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dut2 (
      .clk(clk), .reset(reset), .tick(tick), .data_in(data2), .valid_in(valid2),
      .ready_out(ready2), .tx(tx2), .busy(busy2), .fifo_count(count2)
   );

   task automatic push(input logic [DB-1:0] d);
      @(negedge clk);
      vectors++;
      if (ready_out !== (mfifo.size() < DEPTH)) begin
         errors++;
         $display("FAIL ready_out: got %b, required %b (model holds %0d)", ready_out,
                  mfifo.size() < DEPTH, mfifo.size());
      end
      data_in  = d;
      valid_in = 1'b1;
      if (mfifo.size() < DEPTH) mfifo.push_back(d);
      @(negedge clk);
      valid_in = 1'b0;
      vectors++;
      if (fifo_count !== CW'(mfifo.size())) begin
         errors++;
         $display("FAIL push count: got %0d, required %0d", fifo_count, mfifo.size());
      end
   endtask

   // One baud tick every 16 clocks; the model loads a whole frame when the line runs dry.
   task automatic do_tick();
      logic         exp_tx, exp_busy;
      byte unsigned d;
      @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      if (mline.size() == 0 && mfifo.size() != 0) begin
         d = mfifo.pop_front();
         mline.push_back(1'b0);
         for (int i = 0; i < DB; i++) mline.push_back(d[i]);
         if (PAR != 0) mline.push_back(^d);
         for (int i = 0; i < STOPS; i++) mline.push_back(1'b1);
      end
      if (mline.size() != 0) begin
         exp_tx   = mline.pop_front();
         exp_busy = 1'b1;
      end else begin
         exp_tx   = 1'b1;
         exp_busy = 1'b0;
      end
      vectors++;
      if (tx !== exp_tx) begin
         errors++;
         $display("FAIL tick tx: got %b, required %b", tx, exp_tx);
      end
      vectors++;
      if (busy !== exp_busy) begin
         errors++;
         $display("FAIL tick busy: got %b, required %b", busy, exp_busy);
      end
      vectors++;
      if (fifo_count !== CW'(mfifo.size())) begin
         errors++;
         $display("FAIL tick count: got %0d, required %0d", fifo_count, mfifo.size());
      end
      repeat (14) @(negedge clk);
      vectors++;
      if (tx !== exp_tx) begin
         errors++;
         $display("FAIL hold tx: got %b, required %b", tx, exp_tx);
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((mline.size() != 0 || mfifo.size() != 0) && n < 300) begin
         do_tick();
         n++;
      end
      vectors++;
      if (mline.size() != 0 || mfifo.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d bits / %0d bytes left, required 0", mline.size(),
                  mfifo.size());
      end
      do_tick();
   endtask

   task automatic check_reset_state(input string tag);
      vectors++;
      if ({tx, busy, ready_out, fifo_count} !== {1'b1, 1'b0, 1'b1, CW'(0)}) begin
         errors++;
         $display("FAIL %s: tx/busy/ready/count got %b/%b/%b/%0d, required 1/0/1/0", tag, tx,
                  busy, ready_out, fifo_count);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #12;
      check_reset_state("reset");
      vectors++;
      if ({tx2, busy2, ready2} !== 3'b101) begin
         errors++;
         $display("FAIL reset dut2: tx/busy/ready got %b/%b/%b, required 1/0/1", tx2, busy2,
                  ready2);
      end
      @(negedge clk);
      reset = 1'b0;
      do_tick();
   endtask

   task automatic test_basic();
      push(8'h55);
      drain();
      push(8'h07);
      push(8'h03);
      drain();
   endtask

   task automatic test_back_to_back();
      push(8'hA1);
      push(8'hB2);
      push(8'hC3);
      drain();
   endtask

   task automatic test_full();
      for (int i = 0; i < 5; i++) push(8'(8'h10 + i));
      vectors++;
      if (ready_out !== 1'b0 || fifo_count !== CW'(DEPTH)) begin
         errors++;
         $display("FAIL full: ready/count got %b/%0d, required 0/%0d", ready_out, fifo_count,
                  DEPTH);
      end
      drain();
   endtask

   task automatic async_reset(input string tag);
      @(negedge clk);
      #2 reset = 1'b1;
      #1 check_reset_state(tag);
      mfifo.delete();
      mline.delete();
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_midframe_reset();
      push(8'hFF);
      push(8'h12);
      for (int i = 0; i < 5; i++) do_tick();  // start, then data bits 0..3
      async_reset("reset data3");
      push(8'h3C);
      do_tick();                               // line now low for the start bit
      async_reset("reset start");
      push(8'h5A);
      drain();
   endtask

   task automatic test_random();
      for (int it = 0; it < 40; it++) begin
         for (int p = 0; p < $urandom_range(0, 2); p++) push(8'($urandom));
         do_tick();
      end
      drain();
   endtask

   task automatic test_two_stop();
      int   low_n;
      logic e_tx, e_busy;
      low_n = 1 + DB + PAR;
      @(negedge clk);
      data2  = 8'h00;
      valid2 = 1'b1;
      @(negedge clk);
      valid2 = 1'b0;
      vectors++;
      if (count2 !== CW'(1)) begin
         errors++;
         $display("FAIL two-stop count: got %0d, required 1", count2);
      end
      for (int k = 1; k <= low_n + 3; k++) begin
         do_tick();
         e_tx   = (k > low_n);
         e_busy = (k <= low_n + 2);
         vectors++;
         if (tx2 !== e_tx || busy2 !== e_busy) begin
            errors++;
            $display("FAIL two-stop tick %0d: tx/busy got %b/%b, required %b/%b", k, tx2, busy2,
                     e_tx, e_busy);
         end
      end
   endtask

   initial begin
      tick     = 1'b0;
      valid_in = 1'b0;
      valid2   = 1'b0;
      data_in  = '0;
      data2    = '0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_full();
      test_midframe_reset();
      test_two_stop();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
